uart_stream_arb: RTL
====================

# uart_stream_arb

Frame-level arbiter that shares the single byte-wide UART TX FIFO between two word sources: channel A is the DDC signal-chain output and channel B is a housekeeping/status word. It captures each word into a one-entry holding register and emits it as a header-tagged, MSB-first byte frame. Round-robin arbitration happens at frame boundaries. It sits between the signal chain and the UART transmitter, and replaces the single-source framer.

## Interface
Parameters:
- `NBYTES`, 4: payload bytes per word, both channels; legal range 1..8.
- `SYNC_HI`, 4'hA: upper nibble of every header byte.

Ports:
- `clk`, in, 1: core clock, the only clock.
- `rst`, in, 1: synchronous, active-low reset.
- `a_data_i`, in, 8*NBYTES: channel A word.
- `a_valid_i`, in, 1: channel A word strobe, one cycle per word.
- `a_ready_o`, out, 1: channel A holding register empty.
- `b_data_i`, in, 8*NBYTES: channel B word.
- `b_valid_i`, in, 1: channel B word strobe.
- `b_ready_o`, out, 1: channel B holding register empty.
- `uart_fifo_full_i`, in, 1: UART TX FIFO full.
- `uart_data_o`, out, 8: byte to the FIFO, registered.
- `uart_wr_en_o`, out, 1: FIFO write strobe, registered, one cycle per byte.
- `a_drop_cnt_o`, out, 16: channel A words dropped, saturating.
- `b_drop_cnt_o`, out, 16: channel B words dropped, saturating.
- `busy_o`, out, 1: high in any state other than IDLE.

## Operation
- **Capture:** on each channel, `valid_i` with the holding register empty loads the word and sets the full flag. `valid_i` with the register already full keeps the held word, discards the new word and increments that channel's drop count. The count saturates at 16'hFFFF. `ready_o` is the inverse of the full flag.
- **States:** IDLE, HDR, PAYLOAD, plus CSUM when checksum is compiled in.
- **IDLE:** if any holding register is full, grant one channel and go to HDR.
  - When both are full, the grant goes to the channel not served last.
  - The last-served pointer resets to B, so A wins the first tie.
- **Header byte:** {SYNC_HI, 3'b000, chan}, where A = 0 and B = 1. With defaults this gives 8'hA0 and 8'hA1.
- **Payload:** bytes `[8*NBYTES-1 -: 8]` first, down to `[7:0]`. A byte index counter runs from NBYTES-1 down to 0.
- **Emit rule:** in HDR, PAYLOAD or CSUM, a byte is written on an edge only if `uart_fifo_full_i`=0 and `uart_wr_en_o`=0 in the current cycle. That edge registers the byte, sets `uart_wr_en_o` for one cycle and advances the FSM or index. Otherwise the state holds.
- **End of frame:** after the last byte, the granted holding register clears its full flag, the pointer updates and the FSM returns to IDLE.
- **Simultaneous events:** a new `valid_i` arriving on the same cycle the granted register clears is accepted, not dropped, because the clear has priority over the full check.
- **Reset:** `rst`=0 at any point forces the following, and any partial frame is abandoned; the host resyncs on the header:
  - IDLE state;
  - both holding registers empty;
  - both drop counts 0;
  - pointer to B;
  - `uart_wr_en_o`=0 and `uart_data_o`=8'h00.

## Timing
- **Reset values:**
  - `uart_data_o` = 0, `uart_wr_en_o` = 0;
  - `a_ready_o` = `b_ready_o` = 1;
  - drop counts = 0;
  - `busy_o` = 0.
- **Latency:** with `a_valid_i` sampled at edge 0, the FSM enters HDR at edge 1 and the header is registered at edge 2. `uart_wr_en_o` is first high in cycle 3.
- **Byte spacing:** minimum 2 cycles between `uart_wr_en_o` pulses. A frame of NBYTES+1 bytes takes at least 2*(NBYTES+1) cycles plus 1 IDLE cycle.
- **Back-pressure:** `uart_fifo_full_i` stalls the FSM indefinitely with no byte loss. The one-cycle gap after each write covers the FIFO's registered full flag.
- **Ready:** `a_ready_o` and `b_ready_o` rise in the cycle after the last payload (or CSUM) write edge.

## Configuration
- **`UART_ARB_CHECKSUM_EN` defined:** a CSUM state follows PAYLOAD and emits the XOR of the NBYTES payload bytes; the header is not included. Frame length is NBYTES+2.
- **Undefined:** no CSUM state; frame length is NBYTES+1.

## Structure
- **Package `uart_arb_pkg`:**
  - state enum;
  - `CHAN_A`/`CHAN_B` constants;
  - header build function;
  - drop-counter width (16).
- **Sub-module `word_hold_reg`:** one-entry holding register with full flag, clear input and saturating drop counter. It is instantiated once per channel.

## Test plan
- **Single A word:** `a_data_i`=32'h12345678 pulsed once, FIFO never full → writes A0,12,34,56,78 with the first `uart_wr_en_o` in cycle 3 and 2-cycle spacing. `a_ready_o` returns to 1. `busy_o` falls.
- **Tie:** A=32'h11111111 and B=32'h22222222 strobed in the same cycle → A frame first (A0,11×4), then B frame (A1,22×4). Repeat the tie → A again, because the pointer now points at B.
- **Back-pressure:** hold `uart_fifo_full_i` high for 10 cycles mid-payload → no write while high. The remaining bytes follow in order, with no duplicate and no loss.
- **Overflow:** strobe A three times 1 cycle apart while the FIFO is full → the first word is held, `a_drop_cnt_o`=2, and the first word is the one emitted. Force 70000 drops → the count stays at 16'hFFFF.
- **Reset mid-frame:** drive `rst`=0 after the header and 2 payload bytes → next cycle `uart_wr_en_o`=0, `busy_o`=0, both ready signals 1, counts 0. A new word after release emits a complete frame.
- **Checksum build:** with `UART_ARB_CHECKSUM_EN` defined, A=32'h12345678 → frame A0,12,34,56,78,08.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the two-channel UART frame arbiter.
//   - arb_state_t : frame FSM states (CSUM only exists when the build defines
//                   UART_ARB_CHECKSUM_EN)
//   - CHAN_A/CHAN_B : channel identifiers, also the low bit of the header
//   - DROP_W      : width of the saturating per-channel drop counters
//   - IDX_W       : width of the payload byte index (covers up to 8 bytes)
//   - hdr_byte()  : builds the frame header byte
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int DROP_W = 16;
  localparam int IDX_W  = 3;

  localparam logic CHAN_A = 1'b0;
  localparam logic CHAN_B = 1'b1;

`ifdef UART_ARB_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CSUM
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } arb_state_t;
`endif

  // Header is the sync nibble, three zero bits, then the channel id.
  function automatic logic [7:0] hdr_byte(input logic [3:0] sync_hi,
                                          input logic       chan);
    return {sync_hi, 3'b000, chan};
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// -----------------------------------------------------------------------------
// word_hold_reg
// One-entry holding register for a word source, with a full flag, a clear
// input from the frame FSM and a saturating drop counter.
// Ports:
//   clk, rst      : core clock, synchronous active-low reset
//   data_i        : incoming word
//   valid_i       : word strobe
//   clr_i         : frame using this word has finished; free the entry
//   data_o        : held word
//   full_o        : entry occupied
//   drop_cnt_o    : words discarded because the entry was occupied
// -----------------------------------------------------------------------------
module word_hold_reg
  import uart_arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      data_i,
  input  logic              valid_i,
  input  logic              clr_i,
  output logic [W-1:0]      data_o,
  output logic              full_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  // A clear on this cycle frees the entry before the new word is looked at,
  // so a word arriving on the frame's last edge is captured rather than dropped.
  logic held;
  assign held = full_o & ~clr_i;

  // NOTE: the word storage needs no reset; full_o alone says whether it holds
  // anything meaningful, and leaving it unreset keeps it a plain enable flop.
  always_ff @(posedge clk) begin
    if (valid_i && !held) begin
      data_o <= data_i;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (valid_i) begin
        if (held) begin
          if (drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + DROP_W'(1);
          end
        end else begin
          full_o <= 1'b1;
        end
      end else if (clr_i) begin
        full_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_stream_arb.sv
// -----------------------------------------------------------------------------
// uart_stream_arb
// Shares one byte-wide UART TX FIFO between channel A (signal-chain words) and
// channel B (housekeeping words). Each word is held in a one-entry register
// and sent as a frame: header {SYNC_HI, 3'b000, chan}, then the payload
// MSB byte first. Round-robin between channels at frame boundaries; the
// last-served pointer starts at B so A wins the first tie.
// Build option: define UART_ARB_CHECKSUM_EN to append an XOR-of-payload byte.
// Ports:
//   clk, rst                    : core clock, synchronous active-low reset
//   a_data_i/a_valid_i/a_ready_o: channel A word, strobe, entry empty
//   b_data_i/b_valid_i/b_ready_o: channel B word, strobe, entry empty
//   uart_fifo_full_i            : TX FIFO full (registered in the FIFO)
//   uart_data_o, uart_wr_en_o   : registered byte and write strobe
//   a_drop_cnt_o, b_drop_cnt_o  : saturating dropped-word counts
//   busy_o                      : FSM not idle
// -----------------------------------------------------------------------------
module uart_stream_arb
  import uart_arb_pkg::*;
#(
  parameter int         NBYTES  = 4,
  parameter logic [3:0] SYNC_HI = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   a_data_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [8*NBYTES-1:0]   b_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic                  uart_fifo_full_i,
  output logic [7:0]            uart_data_o,
  output logic                  uart_wr_en_o,
  output logic [DROP_W-1:0]     a_drop_cnt_o,
  output logic [DROP_W-1:0]     b_drop_cnt_o,
  output logic                  busy_o
);

  localparam int W = 8 * NBYTES;

  logic [W-1:0] a_word, b_word, word;
  logic         a_full, b_full;
  logic         clr_a, clr_b;

  arb_state_t   state, state_n;
  logic         grant, grant_n;
  logic         last, last_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]   data_n;
  logic         wr_n;
  logic         emit_ok;
  logic         frame_done;
  logic [7:0]   cur_byte;

  word_hold_reg #(.W(W)) u_hold_a (
    .clk        (clk),
    .rst        (rst),
    .data_i     (a_data_i),
    .valid_i    (a_valid_i),
    .clr_i      (clr_a),
    .data_o     (a_word),
    .full_o     (a_full),
    .drop_cnt_o (a_drop_cnt_o)
  );

  word_hold_reg #(.W(W)) u_hold_b (
    .clk        (clk),
    .rst        (rst),
    .data_i     (b_data_i),
    .valid_i    (b_valid_i),
    .clr_i      (clr_b),
    .data_o     (b_word),
    .full_o     (b_full),
    .drop_cnt_o (b_drop_cnt_o)
  );

  assign a_ready_o = ~a_full;
  assign b_ready_o = ~b_full;
  assign busy_o    = (state != ST_IDLE);

  // Skipping the cycle right after a write gives the FIFO's registered full
  // flag time to reflect that write before the next byte is offered.
  assign emit_ok  = ~uart_fifo_full_i & ~uart_wr_en_o;
  assign word     = (grant == CHAN_A) ? a_word : b_word;
  assign cur_byte = 8'(word >> {idx, 3'b000});

`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0] csum, csum_n;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    last_n     = last;
    idx_n      = idx;
    data_n     = uart_data_o;
    wr_n       = 1'b0;
    frame_done = 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
    csum_n     = csum;
`endif
    unique case (state)
      ST_IDLE: begin
        if (a_full || b_full) begin
          if (a_full && b_full) begin
            grant_n = (last == CHAN_B) ? CHAN_A : CHAN_B;
          end else begin
            grant_n = a_full ? CHAN_A : CHAN_B;
          end
          state_n = ST_HDR;
        end
      end
      ST_HDR: begin
        if (emit_ok) begin
          data_n  = hdr_byte(SYNC_HI, grant);
          wr_n    = 1'b1;
          idx_n   = IDX_W'(NBYTES - 1);
          state_n = ST_PAYLOAD;
`ifdef UART_ARB_CHECKSUM_EN
          csum_n  = 8'h00;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (emit_ok) begin
          data_n = cur_byte;
          wr_n   = 1'b1;
`ifdef UART_ARB_CHECKSUM_EN
          csum_n = csum ^ cur_byte;
`endif
          if (idx == '0) begin
`ifdef UART_ARB_CHECKSUM_EN
            state_n = ST_CSUM;
`else
            frame_done = 1'b1;
`endif
          end else begin
            idx_n = idx - IDX_W'(1);
          end
        end
      end
`ifdef UART_ARB_CHECKSUM_EN
      ST_CSUM: begin
        if (emit_ok) begin
          data_n     = csum;
          wr_n       = 1'b1;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    clr_a = frame_done & (grant == CHAN_A);
    clr_b = frame_done & (grant == CHAN_B);
    if (frame_done) begin
      last_n  = grant;
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      grant        <= CHAN_A;
      last         <= CHAN_B;
      idx          <= '0;
      uart_data_o  <= 8'h00;
      uart_wr_en_o <= 1'b0;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      last         <= last_n;
      idx          <= idx_n;
      uart_data_o  <= data_n;
      uart_wr_en_o <= wr_n;
    end
  end

`ifdef UART_ARB_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum <= 8'h00;
    end else begin
      csum <= csum_n;
    end
  end
`endif

endmodule
